// File: rtl/hamming7_tx_sched.sv
// Two-source round-robin scheduler feeding a registered Hamming(7,4)
// encoder with periodic single-bit error injection.
module hamming7_tx_sched #(
  parameter int INJ_PERIOD = 8,
  parameter int CNT_W      = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_data,
  output logic       req1_ready,
  input  logic       inj_en,
  input  logic [2:0] inj_pos,
  output logic       cw_valid,
  output logic [6:0] cw_data,
  output logic       cw_src,
  output logic       cw_err,
  input  logic       cw_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(INJ_PERIOD - 1);

  state_t           state_q;
  state_t           state_d;
  logic             last_grant;
  logic [CNT_W-1:0] inj_cnt;

  logic       load;
  logic       grant1;
  logic       accept;
  logic       flip;
  logic [3:0] word;
  logic [6:0] code;
  logic [6:0] mask;

  assign cw_valid = (state_q == FULL);
  assign load     = ~cw_valid | cw_ready;

  // Source 1 wins contention only when source 0 was granted last.
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);

  assign req0_ready = load & ~grant1;
  assign req1_ready = load & grant1;
  assign accept     = load & (req0_valid | req1_valid);

  assign word = grant1 ? req1_data : req0_data;

  // Positions 7..1 = d4 d3 d2 p3 d1 p2 p1
  assign code = {
    word[3], word[2], word[1],
    word[1] ^ word[2] ^ word[3],
    word[0],
    word[0] ^ word[2] ^ word[3],
    word[0] ^ word[1] ^ word[3]
  };

  assign flip = accept & inj_en
              & (inj_cnt == CNT_LAST)
              & (inj_pos != 3'd0);

  always_comb begin
    mask = 7'd0;
    if (flip)
      mask = 7'd1 << (inj_pos - 3'd1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (cw_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cw_data    <= 7'd0;
      cw_src     <= 1'b0;
      cw_err     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      cw_data    <= code ^ mask;
      cw_src     <= grant1;
      cw_err     <= flip;
      last_grant <= grant1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inj_cnt <= '0;
    end else if (!inj_en) begin
      inj_cnt <= '0;
    end else if (accept) begin
      if (inj_cnt == CNT_LAST)
        inj_cnt <= '0;
      else
        inj_cnt <= inj_cnt + 1'b1;
    end
  end

endmodule
